// File: rtl/demux14_pkg.sv
// Shared types and constants for the 1:4 serial demultiplexer.
package demux14_pkg;

  localparam int N_SLOTS = 4;
  localparam int SEL_W   = 2;

  typedef enum logic {
    HUNT   = 1'b0,
    LOCKED = 1'b1
  } state_t;

  typedef logic [N_SLOTS-1:0] word_t;

endpackage

// File: rtl/demux14_slot_ctr.sv
// Slot counter: tracks which slot the next accepted bit occupies.
// A sync-qualified accept always lands in slot 0, so the counter restarts at 1.
import demux14_pkg::*;

module demux14_slot_ctr (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             adv,
  input  logic             restart,
  output logic [SEL_W-1:0] sel_cur,
  output logic             last_slot
);

  logic [SEL_W-1:0] sel_d;
  logic [SEL_W-1:0] sel_q;

  // Next slot: restart after a sync bit, otherwise increment with natural wrap.
  always_comb begin
    sel_d = sel_q;
    if (adv) begin
      if (restart) begin
        sel_d = SEL_W'(1);
      end else begin
        sel_d = sel_q + SEL_W'(1);
      end
    end
  end

  // Slot register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sel_q <= '0;
    end else begin
      sel_q <= sel_d;
    end
  end

  assign sel_cur   = sel_q;
  assign last_slot = (sel_q == SEL_W'(N_SLOTS - 1));

endmodule

// File: rtl/demux14_deser.sv
// 1:4 serial-to-parallel demultiplexer with sync-strobe framing and a
// single-entry valid/ready output holding register.
//
// state  | meaning
// HUNT   | waiting for a sync-qualified bit; unframed bits are dropped
// LOCKED | framed; every valid bit is written into the current slot
import demux14_pkg::*;

module demux14_deser (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_bit,
  input  logic               in_valid,
  input  logic               in_sync,
  output logic [N_SLOTS-1:0] out_data,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [SEL_W-1:0]   sel_cur,
  output logic               locked,
  output logic               overrun,
  output logic               sync_err,
  input  logic               clr_flags
);

  state_t state_d, state_q;
  word_t  asm_d, asm_q;
  word_t  out_data_d, out_data_q;
  logic   out_valid_d, out_valid_q;
  logic   overrun_d, overrun_q;
  logic   sync_err_d, sync_err_q;

  logic   accept;
  logic   last_slot;
  logic   word_done;
  logic   load;
  logic   overrun_set;
  logic   sync_err_set;
  word_t  full_word;

  // Bits outside a frame are ignored until the first sync.
  assign accept       = in_valid && ((state_q == LOCKED) || in_sync);
  assign word_done    = accept && !in_sync && last_slot;
  assign full_word    = {in_bit, asm_q[N_SLOTS-2:0]};
  assign load         = word_done && (!out_valid_q || out_ready);
  assign overrun_set  = word_done && out_valid_q && !out_ready;
  assign sync_err_set = in_valid && in_sync && (state_q == LOCKED) && (sel_cur != '0);

  demux14_slot_ctr u_slot_ctr (
    .clk       (clk),
    .rst_n     (rst_n),
    .adv       (accept),
    .restart   (in_sync),
    .sel_cur   (sel_cur),
    .last_slot (last_slot)
  );

  // Next-state, assembly, output holding and sticky flag logic.
  always_comb begin
    state_d     = state_q;
    asm_d       = asm_q;
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;
    overrun_d   = overrun_q;
    sync_err_d  = sync_err_q;

    if (in_valid && in_sync) begin
      state_d = LOCKED;
    end

    if (accept) begin
      if (in_sync) begin
        // A sync restarts the frame; any partial word is discarded.
        asm_d    = '0;
        asm_d[0] = in_bit;
      end else begin
        asm_d[sel_cur] = in_bit;
      end
    end

    if (load) begin
      out_data_d  = full_word;
      out_valid_d = 1'b1;
    end else if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
    end

    // Set beats clear when both happen on the same edge.
    if (clr_flags) begin
      overrun_d  = 1'b0;
      sync_err_d = 1'b0;
    end
    if (overrun_set) begin
      overrun_d = 1'b1;
    end
    if (sync_err_set) begin
      sync_err_d = 1'b1;
    end
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= HUNT;
      asm_q       <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      overrun_q   <= 1'b0;
      sync_err_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      asm_q       <= asm_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      overrun_q   <= overrun_d;
      sync_err_q  <= sync_err_d;
    end
  end

  assign out_data  = out_data_q;
  assign out_valid = out_valid_q;
  assign locked    = (state_q == LOCKED);
  assign overrun   = overrun_q;
  assign sync_err  = sync_err_q;

endmodule

// File: tb/tb_demux14_deser.sv
// Scoreboard bench for demux14_deser: directed scenarios plus random traffic.
module tb_demux14_deser;

  logic       clk;
  logic       rst_n;
  logic       in_bit;
  logic       in_valid;
  logic       in_sync;
  logic [3:0] out_data;
  logic       out_valid;
  logic       out_ready;
  logic [1:0] sel_cur;
  logic       locked;
  logic       overrun;
  logic       sync_err;
  logic       clr_flags;

  int tests_run = 0;
  int tests_failed = 0;

  // reference model state
  bit         m_locked;
  int         m_slot;
  logic [3:0] m_bits;
  bit         m_hold_valid;
  bit         m_over;
  bit         m_serr;
  logic [3:0] exp_q[$];

  demux14_deser dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_bit    (in_bit),
    .in_valid  (in_valid),
    .in_sync   (in_sync),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sel_cur   (sel_cur),
    .locked    (locked),
    .overrun   (overrun),
    .sync_err  (sync_err),
    .clr_flags (clr_flags)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_locked     = 0;
    m_slot       = 0;
    m_bits       = '0;
    m_hold_valid = 0;
    m_over       = 0;
    m_serr       = 0;
    exp_q.delete();
  endtask

  // One clock edge of behaviour, from the pre-edge inputs.
  task automatic model_step(input bit v, input bit b, input bit s, input bit r, input bit c);
    bit         done = 0;
    bit         ov_set = 0;
    bit         se_set = 0;
    logic [3:0] w = '0;
    if (v) begin
      if (s && (!m_locked || m_slot != 0)) begin
        if (m_locked) se_set = 1;
        m_bits    = '0;
        m_bits[0] = b;
        m_slot    = 1;
        m_locked  = 1;
      end else if (m_locked) begin
        m_bits[m_slot] = b;
        if (m_slot == 3) begin
          done = 1;
          w    = m_bits;
        end
        m_slot = (m_slot + 1) % 4;
      end
    end
    if (done && m_hold_valid && !r) begin
      ov_set = 1;
    end else if (done) begin
      m_hold_valid = 1;
      exp_q.push_back(w);
    end else if (m_hold_valid && r) begin
      m_hold_valid = 0;
    end
    if (c) begin
      m_over = 0;
      m_serr = 0;
    end
    if (ov_set) m_over = 1;
    if (se_set) m_serr = 1;
  endtask

  // Drive one cycle of inputs, let the edge happen, advance the model.
  task automatic cycle(input bit v, input bit b, input bit s, input bit r, input bit c);
    in_valid  = v;
    in_bit    = b;
    in_sync   = s;
    out_ready = r;
    clr_flags = c;
    @(posedge clk);
    model_step(v, b, s, r, c);
    #1;
  endtask

  // Send four bits of a word (slot 0 first), optional sync on the first.
  task automatic send_word(input logic [3:0] w, input bit sync_first, input bit r);
    for (int k = 0; k < 4; k++) begin
      cycle(1'b1, w[k], sync_first && (k == 0), r, 1'b0);
    end
  endtask

  task automatic do_reset();
    in_valid  = 0;
    in_bit    = 0;
    in_sync   = 0;
    out_ready = 0;
    clr_flags = 0;
    rst_n     = 0;
    model_reset();
    @(posedge clk);
    #1;
    check("rst_out_data", out_data, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_locked", locked, 0);
    check("rst_sel_cur", sel_cur, 0);
    check("rst_overrun", overrun, 0);
    check("rst_sync_err", sync_err, 0);
    rst_n = 1;
  endtask

  // Monitor: compares observable state and pops delivered words.
  always @(negedge clk) begin
    check("out_valid", out_valid, m_hold_valid);
    check("locked", locked, m_locked);
    check("sel_cur", sel_cur, m_slot);
    check("overrun", overrun, m_over);
    check("sync_err", sync_err, m_serr);
    if (out_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        check("unexpected_word", 1, 0);
      end else begin
        check("out_data", out_data, exp_q[0]);
        if (out_ready === 1'b1) void'(exp_q.pop_front());
      end
    end
  end

  initial begin
    rst_n = 0;
    do_reset();

    // sync + 1,0,0,0
    send_word(4'b0001, 1'b1, 1'b1);
    check("t1_valid", out_valid, 1);
    check("t1_data", out_data, 4'b0001);
    check("t1_sel", sel_cur, 0);
    cycle(0, 0, 0, 1, 0);

    // HUNT: unframed bits with gaps are dropped
    do_reset();
    for (int k = 0; k < 3; k++) begin
      cycle(1, 1, 0, 1, 0);
      cycle(0, 0, 0, 1, 0);
    end
    check("t2_locked", locked, 0);
    check("t2_valid", out_valid, 0);
    send_word(4'b0111, 1'b1, 1'b1);
    check("t2_data", out_data, 4'b0111);
    cycle(0, 0, 0, 1, 0);

    // mid-word resync
    cycle(1, 1, 0, 1, 0);
    cycle(1, 1, 0, 1, 0);
    send_word(4'b1010, 1'b1, 1'b1);
    check("t3_sync_err", sync_err, 1);
    check("t3_data", out_data, 4'b1010);
    cycle(0, 0, 0, 1, 1);

    // overrun with consumer stalled
    send_word(4'b1000, 1'b0, 1'b0);
    send_word(4'b0010, 1'b0, 1'b0);
    check("t4_data", out_data, 4'b1000);
    check("t4_overrun", overrun, 1);
    cycle(0, 0, 0, 0, 1);
    check("t4_clr", overrun, 0);
    cycle(0, 0, 0, 1, 0);

    // consume and reload on the same edge
    send_word(4'b1011, 1'b0, 1'b0);
    cycle(1, 1, 0, 0, 0);
    cycle(1, 0, 0, 0, 0);
    cycle(1, 1, 0, 0, 0);
    cycle(1, 1, 0, 1, 0);
    check("t5_valid", out_valid, 1);
    check("t5_data", out_data, 4'b1101);
    check("t5_overrun", overrun, 0);
    cycle(0, 0, 0, 1, 0);

    // reset mid-word
    cycle(1, 1, 1, 1, 0);
    cycle(1, 0, 0, 1, 0);
    do_reset();
    send_word(4'b0111, 1'b1, 1'b1);
    check("t6_data", out_data, 4'b0111);

    // random traffic
    for (int n = 0; n < 2000; n++) begin
      cycle($urandom_range(99) < 70, 1'($urandom), $urandom_range(99) < 10,
            $urandom_range(99) < 60, $urandom_range(99) < 5);
    end

    for (int n = 0; n < 3; n++) cycle(0, 0, 0, 1, 0);
    @(negedge clk);
    #1;
    check("drain_empty", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
